// File: rtl/pc_sequencer_pkg.sv
// Shared constants and encodings for the fetch PC sequencer and its redirect arbiter.
package pc_sequencer_pkg;

    localparam int WORD = 32;

    localparam logic [WORD-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam int              DEF_PC_INCREMENT = 4;
    localparam int              DEF_ALIGN_BITS   = 2;

    typedef enum logic [1:0] {
        PCS_BOOT  = 2'd0,
        PCS_RUN   = 2'd1,
        PCS_FAULT = 2'd2
    } pcs_state_e;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_TRAP = 2'd1,
        RD_BR   = 2'd2,
        RD_JMP  = 2'd3
    } rd_cause_e;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: trap > branch > jump priority select plus
// alignment check of branch/jump targets. Traps are never alignment-checked.
module pc_redirect_arb
    import pc_sequencer_pkg::*;
#(
    parameter int XLEN       = WORD,
    parameter int ALIGN_BITS = DEF_ALIGN_BITS
) (
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            br_i,
    input  logic [XLEN-1:0] br_addr_i,
    input  logic            jmp_i,
    input  logic [XLEN-1:0] jmp_addr_i,
    input  logic            brjmp_en_i,
    output logic            redir_valid_o,
    output logic [XLEN-1:0] target_o,
    output logic [1:0]      cause_o,
    output logic            misaligned_o
);

    rd_cause_e cause;
    logic      low_bits_nz;

    always_comb begin
        cause    = RD_NONE;
        target_o = '0;
        if (trap_i) begin
            cause    = RD_TRAP;
            target_o = trap_vec_i;
        end else if (br_i && brjmp_en_i) begin
            cause    = RD_BR;
            target_o = br_addr_i;
        end else if (jmp_i && brjmp_en_i) begin
            cause    = RD_JMP;
            target_o = jmp_addr_i;
        end
    end

    generate
        if (ALIGN_BITS > 0) begin : g_align
            assign low_bits_nz = |target_o[ALIGN_BITS-1:0];
        end else begin : g_no_align
            assign low_bits_nz = 1'b0;
        end
    endgenerate

    assign redir_valid_o = (cause != RD_NONE);
    assign cause_o       = cause;
    assign misaligned_o  = low_bits_nz && ((cause == RD_BR) || (cause == RD_JMP));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: holds the fetch PC, offers it to instruction
// memory over valid/ready, and applies trap/branch/jump redirects.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN         = WORD,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter int              PC_INCREMENT = DEF_PC_INCREMENT,
    parameter int              ALIGN_BITS   = DEF_ALIGN_BITS
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trapVec_i,
    input  logic            brBit_i,
    input  logic [XLEN-1:0] brAddr_i,
    input  logic            jmpBit_i,
    input  logic [XLEN-1:0] jmpAddr_i,
    input  logic            fetchReady_i,
    output logic            fetchValid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pcPlus_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] badAddr_o
);

    pcs_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] bad_addr_q, bad_addr_d;

    logic            redir_valid;
    logic [XLEN-1:0] redir_target;
    logic [1:0]      redir_cause;
    logic            redir_misaligned;
    logic            fire;
    logic [XLEN-1:0] pc_inc;

    // Branches and jumps are only honoured while actively fetching.
    pc_redirect_arb #(
        .XLEN       (XLEN),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_arb (
        .trap_i        (trap_i),
        .trap_vec_i    (trapVec_i),
        .br_i          (brBit_i),
        .br_addr_i     (brAddr_i),
        .jmp_i         (jmpBit_i),
        .jmp_addr_i    (jmpAddr_i),
        .brjmp_en_i    (state_q == PCS_RUN),
        .redir_valid_o (redir_valid),
        .target_o      (redir_target),
        .cause_o       (redir_cause),
        .misaligned_o  (redir_misaligned)
    );

    assign fire   = fetch_valid_q & fetchReady_i & ~stall_i;
    assign pc_inc = pc_q + XLEN'(PC_INCREMENT);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        bad_addr_d = bad_addr_q;
        misalign_d = 1'b0;
        case (state_q)
            PCS_BOOT: begin
                state_d = PCS_RUN;
                if (redir_cause == RD_TRAP) begin
                    pc_d = redir_target;
                end
            end
            PCS_RUN: begin
                if (redir_valid) begin
                    if (redir_misaligned) begin
                        bad_addr_d = redir_target;
                        misalign_d = 1'b1;
                        state_d    = PCS_FAULT;
                    end else begin
                        pc_d = redir_target;
                    end
                end else if (fire) begin
                    pc_d = pc_inc;
                end
            end
            PCS_FAULT: begin
                if (redir_cause == RD_TRAP) begin
                    pc_d    = redir_target;
                    state_d = PCS_RUN;
                end
            end
            default: state_d = PCS_BOOT;
        endcase
        // Valid is registered from the next state so it never depends combinationally on inputs.
        fetch_valid_d = (state_d == PCS_RUN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= PCS_BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            bad_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            misalign_q    <= misalign_d;
            bad_addr_q    <= bad_addr_d;
        end
    end

    assign fetchValid_o = fetch_valid_q;
    assign pc_o         = pc_q;
    assign pcPlus_o     = pc_inc;
    assign misalign_o   = misalign_q;
    assign badAddr_o    = bad_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: accepted fetches and misalign pulses are
// checked by a monitor against queues of expected values filled by the stimulus.
module tb_pc_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, trap_i, brBit_i, jmpBit_i, fetchReady_i;
    logic [31:0] trapVec_i, brAddr_i, jmpAddr_i;
    logic        fetchValid_o, misalign_o;
    logic [31:0] pc_o, pcPlus_o, badAddr_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_bad_q[$];

    pc_sequencer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .trap_i       (trap_i),
        .trapVec_i    (trapVec_i),
        .brBit_i      (brBit_i),
        .brAddr_i     (brAddr_i),
        .jmpBit_i     (jmpBit_i),
        .jmpAddr_i    (jmpAddr_i),
        .fetchReady_i (fetchReady_i),
        .fetchValid_o (fetchValid_o),
        .pc_o         (pc_o),
        .pcPlus_o     (pcPlus_o),
        .misalign_o   (misalign_o),
        .badAddr_o    (badAddr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic fv,
                             input logic mis, input logic [31:0] bad);
        chk({tag, " pc"}, pc_o, pc);
        chk({tag, " valid"}, {31'd0, fetchValid_o}, {31'd0, fv});
        chk({tag, " misalign"}, {31'd0, misalign_o}, {31'd0, mis});
        chk({tag, " badAddr"}, badAddr_o, bad);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        if (fetchValid_o === 1'b1 && fetchReady_i === 1'b1 && stall_i === 1'b0) begin
            if (exp_pc_q.size() == 0) begin
                chk("unexpected fire pc", pc_o, 32'hDEAD_BEEF);
            end else begin
                logic [31:0] e;
                e = exp_pc_q.pop_front();
                chk("fire pc", pc_o, e);
                chk("fire pcPlus", pcPlus_o, e + 32'd4);
            end
        end
        if (misalign_o === 1'b1) begin
            if (exp_bad_q.size() == 0) begin
                chk("unexpected misalign badAddr", badAddr_o, 32'hDEAD_BEEF);
            end else begin
                chk("misalign badAddr", badAddr_o, exp_bad_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; trap_i = 1'b0; brBit_i = 1'b0; jmpBit_i = 1'b0;
        fetchReady_i = 1'b1; trapVec_i = '0; brAddr_i = '0; jmpAddr_i = '0;
        step(2);
        chk_state("reset", 32'h0, 1'b0, 1'b0, 32'h0);

        // 1: boot cycle then free run 0,4,8,C
        rst_i = 1'b0;
        chk("boot valid", {31'd0, fetchValid_o}, 32'd0);
        exp_pc_q.push_back(32'h0);
        exp_pc_q.push_back(32'h4);
        exp_pc_q.push_back(32'h8);
        exp_pc_q.push_back(32'hC);
        step(5);
        chk("run pc", pc_o, 32'h10);

        // 2: stall 3 cycles, then not-ready 2 cycles
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("stall pc", pc_o, 32'h10);
            chk("stall valid", {31'd0, fetchValid_o}, 32'd1);
        end
        stall_i = 1'b0; fetchReady_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1);
            chk("notready pc", pc_o, 32'h10);
            chk("notready valid", {31'd0, fetchValid_o}, 32'd1);
        end
        fetchReady_i = 1'b1;
        exp_pc_q.push_back(32'h10);
        step(1);
        chk("after fire pc", pc_o, 32'h14);

        // 3: simultaneous trap/branch/jump under stall
        stall_i = 1'b1;
        trap_i = 1'b1; trapVec_i = 32'h100;
        brBit_i = 1'b1; brAddr_i = 32'h200;
        jmpBit_i = 1'b1; jmpAddr_i = 32'h300;
        step(1);
        chk("priority pc", pc_o, 32'h100);
        chk("priority valid", {31'd0, fetchValid_o}, 32'd1);
        trap_i = 1'b0; brBit_i = 1'b0; jmpBit_i = 1'b0; stall_i = 1'b0;
        exp_pc_q.push_back(32'h100);
        step(1);
        chk("post-trap pc", pc_o, 32'h104);

        // 4: misaligned branch -> FAULT; branch ignored; trap recovers
        fetchReady_i = 1'b0;
        brBit_i = 1'b1; brAddr_i = 32'h202;
        exp_bad_q.push_back(32'h202);
        step(1);
        chk_state("fault entry", 32'h104, 1'b0, 1'b1, 32'h202);
        brAddr_i = 32'h300;
        step(1);
        chk_state("fault hold", 32'h104, 1'b0, 1'b0, 32'h202);
        brBit_i = 1'b0;
        trap_i = 1'b1; trapVec_i = 32'h80;
        step(1);
        chk("fault trap pc", pc_o, 32'h80);
        chk("fault trap valid", {31'd0, fetchValid_o}, 32'd1);
        trap_i = 1'b0; fetchReady_i = 1'b1;
        exp_pc_q.push_back(32'h80);
        step(1);
        chk("recovered pc", pc_o, 32'h84);

        // 5: wrap-around via jump
        fetchReady_i = 1'b0;
        jmpBit_i = 1'b1; jmpAddr_i = 32'hFFFF_FFFC;
        step(1);
        chk("jump pc", pc_o, 32'hFFFF_FFFC);
        chk("jump pcPlus", pcPlus_o, 32'h0);
        jmpBit_i = 1'b0; fetchReady_i = 1'b1;
        exp_pc_q.push_back(32'hFFFF_FFFC);
        step(1);
        chk_state("wrap", 32'h0, 1'b1, 1'b0, 32'h202);
        exp_pc_q.push_back(32'h0);
        step(1);
        chk("after wrap pc", pc_o, 32'h4);

        // 6: reset in FAULT, reset during stall, glitch between edges
        fetchReady_i = 1'b0;
        brBit_i = 1'b1; brAddr_i = 32'h6;
        exp_bad_q.push_back(32'h6);
        step(1);
        chk("fault2 misalign", {31'd0, misalign_o}, 32'd1);
        brBit_i = 1'b0; rst_i = 1'b1;
        step(1);
        chk_state("reset in fault", 32'h0, 1'b0, 1'b0, 32'h0);
        rst_i = 1'b0;
        step(1);
        chk("reboot valid", {31'd0, fetchValid_o}, 32'd1);
        stall_i = 1'b1; fetchReady_i = 1'b1;
        step(2);
        chk("stall2 pc", pc_o, 32'h0);
        rst_i = 1'b1;
        step(1);
        chk_state("reset in stall", 32'h0, 1'b0, 1'b0, 32'h0);
        rst_i = 1'b0; stall_i = 1'b0; fetchReady_i = 1'b0;
        step(1);
        chk("run after reset valid", {31'd0, fetchValid_o}, 32'd1);
        rst_i = 1'b1;
        #3;
        rst_i = 1'b0;
        step(1);
        chk("glitch valid", {31'd0, fetchValid_o}, 32'd1);
        chk("glitch pc", pc_o, 32'h0);

        chk("leftover fires", 32'(exp_pc_q.size()), 32'd0);
        chk("leftover misaligns", 32'(exp_bad_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
